// File: rtl/rc4_pkg.sv
// Shared types, constants and the key-byte helper for the RC4 encrypt slice.
package rc4_pkg;

    typedef logic [7:0] byte_t;

    localparam int unsigned S_SIZE    = 256;
    localparam int unsigned KEY_BYTES = 3;
    localparam int unsigned MAX_MSG   = 32;

    typedef enum logic [3:0] {
        KS_IDLE,
        KS_INIT,
        KS_WAIT,
        KSA_SI,
        KSA_SJ,
        KSA_WR_I,
        KSA_WR_J,
        PRGA_SI,
        PRGA_SJ,
        PRGA_WR_I,
        PRGA_WR_J,
        PRGA_F,
        PRGA_OUT
    } ks_state_t;

    typedef enum logic [2:0] {
        ENC_IDLE,
        ENC_KS,
        ENC_PT_WAIT,
        ENC_CT,
        ENC_CT_WR,
        ENC_DONE
    } enc_state_t;

    // key[23:16] is key byte 0, key[7:0] is key byte 2
    function automatic byte_t keybyte(input logic [23:0] key, input byte_t i);
        case (i % 8'(KEY_BYTES))
            8'd0:    keybyte = key[23:16];
            8'd1:    keybyte = key[15:8];
            default: keybyte = key[7:0];
        endcase
    endfunction

endpackage

// File: rtl/rc4_keystream.sv
// RC4 keystream generator: owns the S memory port, runs INIT/KSA/PRGA and
// hands out MSG_LEN keystream bytes over a ks_valid/ks_ready handshake.
module rc4_keystream
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] key,
    input  logic        ks_ready,
    output logic        ks_valid,
    output logic [7:0]  ks_byte,
    output logic [7:0]  s_address,
    output logic [7:0]  s_data,
    output logic        s_wren,
    input  logic [7:0]  s_q
);

    localparam logic [4:0] LAST_K    = 5'(((MSG_LEN > MAX_MSG) ? MAX_MSG : MSG_LEN) - 1);
    localparam logic [7:0] WAIT_INIT = 8'(RD_LAT - 1);
    localparam byte_t      LAST_I    = 8'(S_SIZE - 1);

    ks_state_t   state, ret;
    byte_t       i, j, si, sj;
    logic [4:0]  k;
    logic [7:0]  wait_cnt;
    logic [23:0] key_q;
    byte_t       j_ksa, j_prga, t_addr;

    always_comb begin
        j_ksa  = j + s_q + keybyte(key_q, i);
        j_prga = j + s_q;
        t_addr = si + sj;
    end

    // Every read parks in KS_WAIT for RD_LAT cycles, then resumes at ret.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= KS_IDLE;
            ret       <= KS_IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            si        <= '0;
            sj        <= '0;
            wait_cnt  <= '0;
            key_q     <= '0;
            ks_valid  <= 1'b0;
            ks_byte   <= '0;
            s_address <= '0;
            s_data    <= '0;
            s_wren    <= 1'b0;
        end else begin
            case (state)
                KS_IDLE: if (start) begin
                    key_q     <= key;
                    i         <= '0;
                    j         <= '0;
                    k         <= '0;
                    s_address <= '0;
                    s_data    <= '0;
                    s_wren    <= 1'b1;
                    state     <= KS_INIT;
                end
                KS_INIT: if (i == LAST_I) begin
                    i         <= '0;
                    j         <= '0;
                    s_wren    <= 1'b0;
                    s_address <= '0;
                    wait_cnt  <= WAIT_INIT;
                    ret       <= KSA_SI;
                    state     <= KS_WAIT;
                end else begin
                    i         <= i + 8'd1;
                    s_address <= i + 8'd1;
                    s_data    <= i + 8'd1;
                end
                KS_WAIT: if (wait_cnt == '0) state <= ret;
                         else wait_cnt <= wait_cnt - 8'd1;
                KSA_SI: begin
                    si        <= s_q;
                    j         <= j_ksa;
                    s_address <= j_ksa;
                    wait_cnt  <= WAIT_INIT;
                    ret       <= KSA_SJ;
                    state     <= KS_WAIT;
                end
                KSA_SJ: begin
                    s_address <= i;
                    s_data    <= s_q;
                    s_wren    <= 1'b1;
                    state     <= KSA_WR_I;
                end
                KSA_WR_I: begin
                    s_address <= j;
                    s_data    <= si;
                    state     <= KSA_WR_J;
                end
                KSA_WR_J: begin
                    s_wren   <= 1'b0;
                    wait_cnt <= WAIT_INIT;
                    state    <= KS_WAIT;
                    if (i == LAST_I) begin
                        i         <= 8'd1;
                        j         <= '0;
                        k         <= '0;
                        s_address <= 8'd1;
                        ret       <= PRGA_SI;
                    end else begin
                        i         <= i + 8'd1;
                        s_address <= i + 8'd1;
                        ret       <= KSA_SI;
                    end
                end
                PRGA_SI: begin
                    si        <= s_q;
                    j         <= j_prga;
                    s_address <= j_prga;
                    wait_cnt  <= WAIT_INIT;
                    ret       <= PRGA_SJ;
                    state     <= KS_WAIT;
                end
                PRGA_SJ: begin
                    sj        <= s_q;
                    s_address <= i;
                    s_data    <= s_q;
                    s_wren    <= 1'b1;
                    state     <= PRGA_WR_I;
                end
                PRGA_WR_I: begin
                    s_address <= j;
                    s_data    <= si;
                    state     <= PRGA_WR_J;
                end
                PRGA_WR_J: begin
                    s_wren    <= 1'b0;
                    s_address <= t_addr;
                    wait_cnt  <= WAIT_INIT;
                    ret       <= PRGA_F;
                    state     <= KS_WAIT;
                end
                PRGA_F: begin
                    ks_byte  <= s_q;
                    ks_valid <= 1'b1;
                    state    <= PRGA_OUT;
                end
                PRGA_OUT: if (ks_ready) begin
                    ks_valid <= 1'b0;
                    if (k == LAST_K) begin
                        state <= KS_IDLE;
                    end else begin
                        k         <= k + 5'd1;
                        i         <= i + 8'd1;
                        s_address <= i + 8'd1;
                        wait_cnt  <= WAIT_INIT;
                        ret       <= PRGA_SI;
                        state     <= KS_WAIT;
                    end
                end
                default: state <= KS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rc4_encrypt_fsm.sv
// RC4 encryptor top: reads plaintext, XORs with the keystream, writes ciphertext.
// Optional plaintext charset check enabled by RC4_PT_CHECK_EN (adds pt_invalid).
module rc4_encrypt_fsm
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] key,
    output logic        busy,
    output logic        done,
    output logic [7:0]  s_address,
    output logic [7:0]  s_data,
    output logic        s_wren,
    input  logic [7:0]  s_q,
    output logic [4:0]  pt_address,
    input  logic [7:0]  pt_q,
    output logic [4:0]  ct_address,
    output logic [7:0]  ct_data,
    output logic        ct_wren
`ifdef RC4_PT_CHECK_EN
    ,
    output logic        pt_invalid
`endif
);

    localparam logic [4:0] LAST_K    = 5'(((MSG_LEN > MAX_MSG) ? MAX_MSG : MSG_LEN) - 1);
    localparam logic [7:0] WAIT_INIT = 8'(RD_LAT - 1);

    enc_state_t state;
    logic [4:0] k;
    byte_t      f;
    logic [7:0] wait_cnt;
    logic       ks_start, ks_ready, ks_valid;
    byte_t      ks_byte;

    // Gating start by IDLE keeps a start during busy from reaching the generator.
    assign ks_start = start && (state == ENC_IDLE);
    assign ks_ready = (state == ENC_KS);

    rc4_keystream #(
        .MSG_LEN (MSG_LEN),
        .RD_LAT  (RD_LAT)
    ) u_keystream (
        .clock     (clock),
        .reset     (reset),
        .start     (ks_start),
        .key       (key),
        .ks_ready  (ks_ready),
        .ks_valid  (ks_valid),
        .ks_byte   (ks_byte),
        .s_address (s_address),
        .s_data    (s_data),
        .s_wren    (s_wren),
        .s_q       (s_q)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ENC_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            k          <= '0;
            f          <= '0;
            wait_cnt   <= '0;
            pt_address <= '0;
            ct_address <= '0;
            ct_data    <= '0;
            ct_wren    <= 1'b0;
`ifdef RC4_PT_CHECK_EN
            pt_invalid <= 1'b0;
`endif
        end else begin
            case (state)
                ENC_IDLE: if (start) begin
                    busy  <= 1'b1;
                    done  <= 1'b0;
                    k     <= '0;
                    state <= ENC_KS;
`ifdef RC4_PT_CHECK_EN
                    pt_invalid <= 1'b0;
`endif
                end
                ENC_KS: if (ks_valid) begin
                    f          <= ks_byte;
                    pt_address <= k;
                    wait_cnt   <= WAIT_INIT;
                    state      <= ENC_PT_WAIT;
                end
                ENC_PT_WAIT: if (wait_cnt == '0) state <= ENC_CT;
                             else wait_cnt <= wait_cnt - 8'd1;
                ENC_CT: begin
                    ct_address <= k;
                    ct_data    <= f ^ pt_q;
                    ct_wren    <= 1'b1;
                    state      <= ENC_CT_WR;
`ifdef RC4_PT_CHECK_EN
                    if ((pt_q < 8'h61 || pt_q > 8'h7A) && pt_q != 8'h20)
                        pt_invalid <= 1'b1;
`endif
                end
                ENC_CT_WR: begin
                    ct_wren <= 1'b0;
                    if (k == LAST_K) begin
                        state <= ENC_DONE;
                    end else begin
                        k     <= k + 5'd1;
                        state <= ENC_KS;
                    end
                end
                ENC_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ENC_IDLE;
                end
                default: state <= ENC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_encrypt_fsm.sv
// Scoreboard bench for rc4_encrypt_fsm against a plain-array RC4 reference.
module tb_rc4_encrypt_fsm;

    localparam int unsigned N = 32;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [23:0] key;
    logic        busy, done;
    logic [7:0]  s_address, s_data, s_q;
    logic        s_wren;
    logic [4:0]  pt_address, ct_address;
    logic [7:0]  pt_q, ct_data;
    logic        ct_wren;
`ifdef RC4_PT_CHECK_EN
    logic        pt_invalid;
`endif

    always #5 clock = ~clock;

    rc4_encrypt_fsm #(
        .MSG_LEN (N),
        .RD_LAT  (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .s_address  (s_address),
        .s_data     (s_data),
        .s_wren     (s_wren),
        .s_q        (s_q),
        .pt_address (pt_address),
        .pt_q       (pt_q),
        .ct_address (ct_address),
        .ct_data    (ct_data),
        .ct_wren    (ct_wren)
`ifdef RC4_PT_CHECK_EN
        ,
        .pt_invalid (pt_invalid)
`endif
    );

    logic [7:0] s_mem [256];
    logic [7:0] pt_mem [N];
    logic [7:0] ct_mem [N];
    logic [7:0] ref_ct [N];
    logic [7:0] orig_pt [N];
    logic [7:0] kv [9];
    logic [12:0] exp_q [$];

    int n_vec = 0;
    int n_miss = 0;
    int swren_cnt = 0;
    int ct_cnt = 0;

    always @(posedge clock) begin
        if (s_wren) s_mem[s_address] <= s_data;
        s_q  <= s_mem[s_address];
        pt_q <= pt_mem[pt_address];
        if (ct_wren) ct_mem[ct_address] <= ct_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ciphertext write is matched against the next expected entry.
    always @(negedge clock) begin
        logic [12:0] e;
        if (s_wren) swren_cnt++;
        if (ct_wren) begin
            ct_cnt++;
            if (exp_q.size() == 0) begin
                check("ct_unexpected", {3'b0, ct_address, ct_data}, 16'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("ct_write", {ct_address, ct_data}, e);
            end
        end
    end

    task automatic compute_ref(input logic [23:0] k);
        int s [256];
        int i, j, t;
        logic [7:0] kb [3];
        kb[0] = k[23:16];
        kb[1] = k[15:8];
        kb[2] = k[7:0];
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + int'(kb[n % 3])) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        for (int n = 0; n < N; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ref_ct[n] = 8'(s[(s[i] + s[j]) % 256]) ^ pt_mem[n];
        end
    endtask

    task automatic run_enc(input logic [23:0] k, input int pulse_at, output int lat);
        compute_ref(k);
        for (int n = 0; n < N; n++) exp_q.push_back({5'(n), ref_ct[n]});
        swren_cnt = 0;
        @(negedge clock);
        key = k;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        key = '0;
        lat = 1;
        while (!done && lat < 5000) begin
            start = (lat == pulse_at);
            key = start ? 24'hFFFFFF : 24'h0;
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        check("done_busy", {done, busy}, 2'b10);
        check("sb_drained", exp_q.size(), 0);
        exp_q.delete();
        check("s_wren_count", swren_cnt, 832);
    endtask

    task automatic load_known();
        string msg = "Plaintext";
        for (int n = 0; n < N; n++) pt_mem[n] = 8'($urandom_range(97, 122));
        for (int n = 0; n < 9; n++) pt_mem[n] = msg[n];
    endtask

    task automatic check_known();
        for (int n = 0; n < 9; n++) check("known_ct", ct_mem[n], kv[n]);
    endtask

    initial begin
        int lat1, lat2, lat_a, lat_b, c0;
        kv = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        for (int n = 0; n < 256; n++) s_mem[n] = 8'($urandom);
        for (int n = 0; n < N; n++) ct_mem[n] = '0;
        reset = 1'b1;
        start = 1'b0;
        key = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_outputs", {busy, done, s_wren, ct_wren, s_address, s_data,
                                pt_address, ct_address, ct_data}, '0);

        // known vector
        load_known();
        run_enc(24'h4B6579, -1, lat1);
        check_known();
`ifdef RC4_PT_CHECK_EN
        check("pt_invalid_set", pt_invalid, 1'b1);
`endif

        // round trip
        for (int n = 0; n < N; n++) begin
            pt_mem[n] = 8'($urandom_range(97, 122));
            orig_pt[n] = pt_mem[n];
        end
        run_enc(24'h000249, -1, lat2);
`ifdef RC4_PT_CHECK_EN
        check("pt_invalid_clear", pt_invalid, 1'b0);
`endif
        for (int n = 0; n < N; n++) pt_mem[n] = ct_mem[n];
        run_enc(24'h000249, -1, lat2);
        for (int n = 0; n < N; n++) check("round_trip", ct_mem[n], orig_pt[n]);

        // reset in the 300th cycle after start
        load_known();
        c0 = ct_cnt;
        @(negedge clock);
        key = 24'h4B6579;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (298) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_outputs", {busy, done, s_wren, ct_wren}, 4'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("abort_no_ct", ct_cnt - c0, 0);
        for (int n = 0; n < N; n++) ct_mem[n] = '0;
        run_enc(24'h4B6579, -1, lat2);
        check_known();
        check("latency_after_abort", lat2, lat1);

        // start pulsed during PRGA with another key
        for (int n = 0; n < N; n++) ct_mem[n] = '0;
        run_enc(24'h4B6579, 1850, lat2);
        check_known();
        check("latency_with_pulse", lat2, lat1);

        // latency independent of key
        for (int n = 0; n < N; n++) pt_mem[n] = 8'($urandom);
        run_enc(24'h000000, -1, lat_a);
        run_enc(24'hFFFFFF, -1, lat_b);
        check("latency_key_indep", lat_a, lat_b);
        check("latency_vs_first", lat_a, lat1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
